// File: rtl/reorder_buffer.sv
// In-order retirement buffer: accepts tagged execute results out of order and
// retires them in program order, squashing everything on a mispredicted branch.
module reorder_buffer #(
  parameter int ROB_SIZE_LOG  = 2,
  parameter int RD_W          = 2,
  parameter int REG_LEN       = 8,
  parameter int MEMI_SIZE_LOG = 4,
  parameter int MEMD_SIZE_LOG = 4
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [MEMI_SIZE_LOG-1:0]   alloc_pc,
  input  logic [RD_W-1:0]            alloc_rd,
  input  logic                       alloc_wen,
  input  logic                       alloc_is_br,
  input  logic                       alloc_is_st,
  output logic [ROB_SIZE_LOG-1:0]    alloc_idx,

  input  logic                       wb_valid,
  input  logic [ROB_SIZE_LOG-1:0]    wb_idx,
  input  logic [REG_LEN-1:0]         wb_rd_data,
  input  logic [MEMI_SIZE_LOG-1:0]   wb_next_pc,
  input  logic [MEMD_SIZE_LOG-1:0]   wb_mem_addr,
  input  logic [REG_LEN-1:0]         wb_mem_data,

  output logic                       commit_valid,
  output logic [RD_W-1:0]            commit_rd,
  output logic [REG_LEN-1:0]         commit_rd_data,
  output logic                       commit_wen,
  output logic                       commit_st,
  output logic [MEMD_SIZE_LOG-1:0]   commit_mem_addr,
  output logic [REG_LEN-1:0]         commit_mem_data,
  output logic                       squash,
  output logic [MEMI_SIZE_LOG-1:0]   redirect_pc,
  output logic [ROB_SIZE_LOG:0]      count
);

  localparam int DEPTH = 1 << ROB_SIZE_LOG;
  localparam int PTR_W = ROB_SIZE_LOG + 1;

  typedef struct packed {
    logic [MEMI_SIZE_LOG-1:0] pc;
    logic [RD_W-1:0]          rd;
    logic                     wen;
    logic                     is_br;
    logic                     is_st;
    logic [REG_LEN-1:0]       rd_data;
    logic [MEMI_SIZE_LOG-1:0] next_pc;
    logic [MEMD_SIZE_LOG-1:0] mem_addr;
    logic [REG_LEN-1:0]       mem_data;
  } entry_t;

  entry_t                  ent_q [DEPTH];
  entry_t                  ent_d [DEPTH];
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        done_q, done_d;
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;

  logic [ROB_SIZE_LOG-1:0] head_idx;
  logic [ROB_SIZE_LOG-1:0] tail_idx;
  entry_t                  head_ent;
  logic                    empty;
  logic                    full;
  logic                    retire;
  logic                    mispredict;
  logic                    flush;
  logic                    alloc_fire;

  assign head_idx = head_q[ROB_SIZE_LOG-1:0];
  assign tail_idx = tail_q[ROB_SIZE_LOG-1:0];
  assign head_ent = ent_q[head_idx];

  // The top pointer bit is a wrap flag that separates full from empty.
  assign empty = (head_q == tail_q);
  assign full  = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

  assign retire     = !empty && valid_q[head_idx] && done_q[head_idx];
  assign mispredict = head_ent.is_br &&
                      (head_ent.next_pc != (head_ent.pc + MEMI_SIZE_LOG'(1)));
  assign flush      = retire && mispredict;
  assign alloc_fire = alloc_valid && alloc_ready;

  assign alloc_ready = !full && !flush;
  assign alloc_idx   = tail_idx;
  assign count       = tail_q - head_q;

  // Retirement outputs are held at zero whenever nothing retires.
  assign commit_valid    = retire;
  assign commit_rd       = retire ? head_ent.rd       : '0;
  assign commit_rd_data  = retire ? head_ent.rd_data  : '0;
  assign commit_wen      = retire && head_ent.wen;
  assign commit_st       = retire && head_ent.is_st;
  assign commit_mem_addr = retire ? head_ent.mem_addr : '0;
  assign commit_mem_data = retire ? head_ent.mem_data : '0;
  assign squash          = flush;
  assign redirect_pc     = flush ? head_ent.next_pc   : '0;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    ent_d   = ent_q;
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;

    if (wb_valid && valid_q[wb_idx] && !flush) begin
      ent_d[wb_idx].rd_data  = wb_rd_data;
      ent_d[wb_idx].next_pc  = wb_next_pc;
      ent_d[wb_idx].mem_addr = wb_mem_addr;
      ent_d[wb_idx].mem_data = wb_mem_data;
      done_d[wb_idx]         = 1'b1;
    end

    if (alloc_fire) begin
      ent_d[tail_idx].pc    = alloc_pc;
      ent_d[tail_idx].rd    = alloc_rd;
      ent_d[tail_idx].wen   = alloc_wen;
      ent_d[tail_idx].is_br = alloc_is_br;
      ent_d[tail_idx].is_st = alloc_is_st;
      valid_d[tail_idx]     = 1'b1;
      done_d[tail_idx]      = 1'b0;
      tail_d                = tail_q + PTR_W'(1);
    end

    if (retire) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PTR_W'(1);
    end

    // A mispredict empties the buffer: the tail lands on the advanced head.
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      tail_d  = head_q + PTR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // NOTE: payload storage has no reset; valid/done gate every use of it.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic,
// all compared against a queue-based program-order model.
module tb_reorder_buffer;

  localparam int LOG   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid, alloc_ready;
  logic [3:0] alloc_pc;
  logic [1:0] alloc_rd;
  logic       alloc_wen, alloc_is_br, alloc_is_st;
  logic [1:0] alloc_idx;
  logic       wb_valid;
  logic [1:0] wb_idx;
  logic [7:0] wb_rd_data;
  logic [3:0] wb_next_pc, wb_mem_addr;
  logic [7:0] wb_mem_data;
  logic       commit_valid;
  logic [1:0] commit_rd;
  logic [7:0] commit_rd_data;
  logic       commit_wen, commit_st;
  logic [3:0] commit_mem_addr;
  logic [7:0] commit_mem_data;
  logic       squash;
  logic [3:0] redirect_pc;
  logic [2:0] count;

  reorder_buffer #(
    .ROB_SIZE_LOG(LOG), .RD_W(2), .REG_LEN(8), .MEMI_SIZE_LOG(4), .MEMD_SIZE_LOG(4)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_rd(alloc_rd), .alloc_wen(alloc_wen), .alloc_is_br(alloc_is_br),
    .alloc_is_st(alloc_is_st), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_rd_data(wb_rd_data),
    .wb_next_pc(wb_next_pc), .wb_mem_addr(wb_mem_addr), .wb_mem_data(wb_mem_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_rd_data(commit_rd_data),
    .commit_wen(commit_wen), .commit_st(commit_st), .commit_mem_addr(commit_mem_addr),
    .commit_mem_data(commit_mem_data), .squash(squash), .redirect_pc(redirect_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       alloc_valid;
    logic [3:0] alloc_pc;
    logic [1:0] alloc_rd;
    logic       alloc_wen;
    logic       alloc_is_br;
    logic       alloc_is_st;
    logic       wb_valid;
    logic [1:0] wb_idx;
    logic [7:0] wb_rd_data;
    logic [3:0] wb_next_pc;
    logic [3:0] wb_mem_addr;
    logic [7:0] wb_mem_data;
  } stim_t;

  // Model entry: an instruction in program order, identified by its sequence number.
  typedef struct {
    int         seq;
    logic [3:0] pc;
    logic [1:0] rd;
    bit         wen, is_br, is_st, done;
    logic [7:0] rd_data;
    logic [3:0] next_pc;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
  } ent_t;

  ent_t q[$];
  int   next_seq = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       cap_ready, cap_commit, cap_squash, cap_wen, cap_st;
  logic [1:0] cap_idx, cap_rd;
  logic [2:0] cap_count;
  logic [7:0] cap_rd_data, cap_mdata;
  logic [3:0] cap_redirect, cap_maddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    alloc_valid = s.alloc_valid;  alloc_pc    = s.alloc_pc;     alloc_rd    = s.alloc_rd;
    alloc_wen   = s.alloc_wen;    alloc_is_br = s.alloc_is_br;  alloc_is_st = s.alloc_is_st;
    wb_valid    = s.wb_valid;     wb_idx      = s.wb_idx;       wb_rd_data  = s.wb_rd_data;
    wb_next_pc  = s.wb_next_pc;   wb_mem_addr = s.wb_mem_addr;  wb_mem_data = s.wb_mem_data;
  endtask

  // One clock cycle: drive, compare against model predictions, then advance the model.
  task automatic step(input stim_t s);
    bit   ec, es, er;
    ent_t e;
    @(negedge clk);
    apply(s);
    #1;
    ec = (q.size() > 0) && q[0].done;
    es = 1'b0;
    if (ec) es = q[0].is_br && (q[0].next_pc != 4'(q[0].pc + 4'd1));
    er = (q.size() < DEPTH) && !es;

    cap_ready = alloc_ready;  cap_idx = alloc_idx;  cap_count = count;
    cap_commit = commit_valid; cap_squash = squash; cap_redirect = redirect_pc;
    cap_rd = commit_rd; cap_rd_data = commit_rd_data; cap_wen = commit_wen;
    cap_st = commit_st; cap_maddr = commit_mem_addr; cap_mdata = commit_mem_data;

    check("alloc_ready", alloc_ready, er);
    check("alloc_idx", alloc_idx, next_seq % DEPTH);
    check("count", count, q.size());
    check("commit_valid", commit_valid, ec);
    check("squash", squash, es);
    if (ec) begin
      check("commit_wen", commit_wen, q[0].wen);
      check("commit_st", commit_st, q[0].is_st);
      check("commit_rd", commit_rd, q[0].rd);
      check("commit_rd_data", commit_rd_data, q[0].rd_data);
      check("commit_mem_addr", commit_mem_addr, q[0].mem_addr);
      check("commit_mem_data", commit_mem_data, q[0].mem_data);
      if (es) check("redirect_pc", redirect_pc, q[0].next_pc);
    end else begin
      check("commit_wen_idle", commit_wen, 0);
      check("commit_st_idle", commit_st, 0);
    end

    @(posedge clk);
    if (s.wb_valid && !es) begin
      for (int k = 0; k < q.size(); k++) begin
        if (q[k].seq % DEPTH == int'(s.wb_idx)) begin
          q[k].rd_data  = s.wb_rd_data;
          q[k].next_pc  = s.wb_next_pc;
          q[k].mem_addr = s.wb_mem_addr;
          q[k].mem_data = s.wb_mem_data;
          q[k].done     = 1'b1;
        end
      end
    end
    if (ec) begin
      if (es) begin
        next_seq = q[0].seq + 1;
        q.delete();
      end else begin
        void'(q.pop_front());
      end
    end
    if (s.alloc_valid && er) begin
      e = '{seq: next_seq, pc: s.alloc_pc, rd: s.alloc_rd, wen: s.alloc_wen,
            is_br: s.alloc_is_br, is_st: s.alloc_is_st, done: 1'b0,
            rd_data: 8'h0, next_pc: 4'h0, mem_addr: 4'h0, mem_data: 8'h0};
      q.push_back(e);
      next_seq++;
    end
  endtask

  function automatic stim_t alloc_stim(input logic [3:0] pc, input logic [1:0] rd,
                                       input logic wen, input logic br, input logic st);
    stim_t s;
    s = '0;
    s.alloc_valid = 1'b1; s.alloc_pc = pc; s.alloc_rd = rd;
    s.alloc_wen = wen; s.alloc_is_br = br; s.alloc_is_st = st;
    return s;
  endfunction

  function automatic stim_t wb_stim(input logic [1:0] idx, input logic [7:0] data,
                                    input logic [3:0] npc, input logic [3:0] maddr,
                                    input logic [7:0] mdata);
    stim_t s;
    s = '0;
    s.wb_valid = 1'b1; s.wb_idx = idx; s.wb_rd_data = data;
    s.wb_next_pc = npc; s.wb_mem_addr = maddr; s.wb_mem_data = mdata;
    return s;
  endfunction

  // Write back the oldest pending entry (non-mispredicting) until the model is empty.
  task automatic drain();
    stim_t s;
    for (int n = 0; n < 16 && q.size() > 0; n++) begin
      s = idle_stim();
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (!q[k].done) s = wb_stim(2'(q[k].seq % DEPTH), 8'($urandom), 4'(q[k].pc + 4'd1), 4'h0, 8'h0);
      end
      step(s);
    end
    step(idle_stim());
    check("drained_count", cap_count, 0);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    int    k;
    s = '0;
    s.alloc_valid = ($urandom_range(0, 9) < 6);
    s.alloc_pc    = 4'($urandom);
    s.alloc_rd    = 2'($urandom);
    s.alloc_wen   = 1'($urandom);
    s.alloc_is_br = ($urandom_range(0, 3) == 0);
    s.alloc_is_st = !s.alloc_is_br && ($urandom_range(0, 3) == 0);
    s.wb_rd_data  = 8'($urandom);
    s.wb_mem_addr = 4'($urandom);
    s.wb_mem_data = 8'($urandom);
    s.wb_next_pc  = 4'($urandom);
    if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
      k = $urandom_range(0, q.size() - 1);
      s.wb_valid = 1'b1;
      s.wb_idx   = 2'(q[k].seq % DEPTH);
      if ($urandom_range(0, 3) != 0) s.wb_next_pc = 4'(q[k].pc + 4'd1);
    end else if ($urandom_range(0, 9) == 0) begin
      s.wb_valid = 1'b1;
      s.wb_idx   = 2'($urandom);
    end
    return s;
  endfunction

  initial begin
    stim_t s;
    int    guard;
    rst = 1'b1;
    apply(idle_stim());
    #3;
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_idx", alloc_idx, 0);
    check("rst_count", count, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_rd", commit_rd, 0);
    check("rst_commit_rd_data", commit_rd_data, 0);
    check("rst_commit_wen", commit_wen, 0);
    check("rst_commit_st", commit_st, 0);
    check("rst_commit_mem_addr", commit_mem_addr, 0);
    check("rst_commit_mem_data", commit_mem_data, 0);
    check("rst_squash", squash, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill the buffer; the fifth request must be refused.
    for (int i = 0; i < 4; i++) begin
      step(alloc_stim(4'(i), 2'(i), 1'b1, 1'b0, 1'b0));
      check("fill_idx", cap_idx, i);
    end
    step(alloc_stim(4'h4, 2'h0, 1'b1, 1'b0, 1'b0));
    check("full_ready", cap_ready, 0);
    check("full_count", cap_count, 4);

    // Out-of-order writeback, in-order retirement.
    step(wb_stim(2'd2, 8'h22, 4'h3, 4'h0, 8'h0));
    check("ooo_wb2_commit", cap_commit, 0);
    step(wb_stim(2'd0, 8'h00, 4'h1, 4'h0, 8'h0));
    check("ooo_wb0_commit", cap_commit, 0);
    step(wb_stim(2'd3, 8'h33, 4'h4, 4'h0, 8'h0));
    check("ooo_c0_valid", cap_commit, 1);
    check("ooo_c0_data", cap_rd_data, 8'h00);
    step(wb_stim(2'd1, 8'h11, 4'h2, 4'h0, 8'h0));
    check("ooo_wait_idx1", cap_commit, 0);
    step(idle_stim());
    check("ooo_c1_data", cap_rd_data, 8'h11);
    check("ooo_c1_rd", cap_rd, 1);
    step(idle_stim());
    check("ooo_c2_data", cap_rd_data, 8'h22);
    step(idle_stim());
    check("ooo_c3_data", cap_rd_data, 8'h33);
    check("ooo_c3_valid", cap_commit, 1);

    // Full buffer with a commit: alloc is refused that cycle, accepted the next.
    for (int i = 0; i < 4; i++) step(alloc_stim(4'(i), 2'(i), 1'b1, 1'b0, 1'b0));
    s = wb_stim(2'd0, 8'h5C, 4'h1, 4'h0, 8'h0);
    s.alloc_valid = 1'b1;
    step(s);
    check("fullc_ready0", cap_ready, 0);
    step(alloc_stim(4'h9, 2'h3, 1'b1, 1'b0, 1'b0));
    check("fullc_commit", cap_commit, 1);
    check("fullc_blocked", cap_ready, 0);
    step(alloc_stim(4'h9, 2'h3, 1'b1, 1'b0, 1'b0));
    check("fullc_accept", cap_ready, 1);
    check("fullc_idx", cap_idx, 0);
    step(idle_stim());
    check("fullc_count", cap_count, 4);
    drain();

    // Mispredicted branch squashes two younger, completed entries.
    step(alloc_stim(4'h5, 2'h0, 1'b0, 1'b1, 1'b0));
    step(alloc_stim(4'h6, 2'h1, 1'b1, 1'b0, 1'b0));
    step(alloc_stim(4'h7, 2'h2, 1'b1, 1'b0, 1'b0));
    step(wb_stim(2'(q[2].seq % DEPTH), 8'hA2, 4'h8, 4'h0, 8'h0));
    step(wb_stim(2'(q[1].seq % DEPTH), 8'hA1, 4'h7, 4'h0, 8'h0));
    step(wb_stim(2'(q[0].seq % DEPTH), 8'h00, 4'h9, 4'h0, 8'h0));
    step(idle_stim());
    check("br_squash", cap_squash, 1);
    check("br_redirect", cap_redirect, 9);
    check("br_ready", cap_ready, 0);
    step(idle_stim());
    check("br_count0", cap_count, 0);
    check("br_no_commit", cap_commit, 0);
    step(idle_stim());
    check("br_no_commit2", cap_commit, 0);

    // Correctly predicted branch, then a normal commit; then pc wrap at 15 -> 0.
    step(alloc_stim(4'h5, 2'h0, 1'b0, 1'b1, 1'b0));
    step(alloc_stim(4'h6, 2'h2, 1'b1, 1'b0, 1'b0));
    step(wb_stim(2'(q[0].seq % DEPTH), 8'h00, 4'h6, 4'h0, 8'h0));
    step(wb_stim(2'(q[1].seq % DEPTH), 8'h5A, 4'h7, 4'h0, 8'h0));
    check("brok_commit", cap_commit, 1);
    check("brok_squash", cap_squash, 0);
    check("brok_wen", cap_wen, 0);
    step(idle_stim());
    check("brok_next_data", cap_rd_data, 8'h5A);
    check("brok_next_wen", cap_wen, 1);
    step(alloc_stim(4'hF, 2'h1, 1'b0, 1'b1, 1'b0));
    step(wb_stim(2'(q[0].seq % DEPTH), 8'h00, 4'h0, 4'h0, 8'h0));
    step(idle_stim());
    check("wrap_commit", cap_commit, 1);
    check("wrap_squash", cap_squash, 0);

    // Store retiring from index 1.
    guard = 0;
    while (next_seq % DEPTH != 1 && guard < 8) begin
      step(alloc_stim(4'h2, 2'h0, 1'b1, 1'b0, 1'b0));
      step(wb_stim(2'(q[q.size()-1].seq % DEPTH), 8'h01, 4'h3, 4'h0, 8'h0));
      guard++;
    end
    drain();
    step(alloc_stim(4'h8, 2'h3, 1'b0, 1'b0, 1'b1));
    check("st_idx", cap_idx, 1);
    step(wb_stim(2'd1, 8'hEE, 4'h9, 4'h3, 8'h07));
    step(idle_stim());
    check("st_commit_st", cap_st, 1);
    check("st_mem_addr", cap_maddr, 3);
    check("st_mem_data", cap_mdata, 8'h07);
    check("st_wen", cap_wen, 0);

    for (int n = 0; n < 600; n++) step(rand_stim());

    // Reset in the middle of traffic clears everything at once.
    for (int n = 0; n < 8 && q.size() < 2; n++) step(alloc_stim(4'h1, 2'h1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    apply(idle_stim());
    #2;
    rst = 1'b1;
    #1;
    check("mrst_count", count, 0);
    check("mrst_commit", commit_valid, 0);
    check("mrst_squash", squash, 0);
    check("mrst_ready", alloc_ready, 1);
    check("mrst_idx", alloc_idx, 0);
    q.delete();
    next_seq = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 100; n++) step(rand_stim());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the simpleooo core. It sits downstream of the execute stage: it accepts results (`rd_data`, `next_pc`, `mem_addr`, `mem_data`) tagged with a buffer index and retires them in program order, one per cycle. Retirement drives register-file writes and data-memory stores. On a mispredicted branch, which predicts not-taken, it issues a full squash and a redirect.

## Interface
- `ROB_SIZE_LOG`, default 2: log2 of entry count; DEPTH = 2^ROB_SIZE_LOG.
- `RD_W`, default 2: destination register index width.
- Data widths come from `src/simpleooo/param.v`: `REG_LEN`, `MEMI_SIZE_LOG`, `MEMD_SIZE_LOG`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alloc_valid`  in  1  dispatch requests an entry.
- `alloc_ready`  out  1  entry available; equals !full && !squash.
- `alloc_pc`  in  MEMI_SIZE_LOG  instruction pc.
- `alloc_rd`  in  RD_W  destination register.
- `alloc_wen`  in  1  instruction writes rd.
- `alloc_is_br`  in  1  branch.
- `alloc_is_st`  in  1  store.
- `alloc_idx`  out  ROB_SIZE_LOG  index assigned on an accepted alloc (tail).
- `wb_valid`  in  1  execute result valid.
- `wb_idx`  in  ROB_SIZE_LOG  target entry.
- `wb_rd_data`  in  REG_LEN  result.
- `wb_next_pc`  in  MEMI_SIZE_LOG  resolved next pc.
- `wb_mem_addr`  in  MEMD_SIZE_LOG  store address.
- `wb_mem_data`  in  REG_LEN  store data.
- `commit_valid`  out  1  head entry retires this cycle.
- `commit_rd`  out  RD_W  retiring rd.
- `commit_rd_data`  out  REG_LEN  retiring value.
- `commit_wen`  out  1  commit_valid && head wen.
- `commit_st`  out  1  commit_valid && head is_st.
- `commit_mem_addr`  out  MEMD_SIZE_LOG  store address.
- `commit_mem_data`  out  REG_LEN  store data.
- `squash`  out  1  head is a mispredicted branch retiring this cycle.
- `redirect_pc`  out  MEMI_SIZE_LOG  correct fetch pc; valid when squash.
- `count`  out  ROB_SIZE_LOG+1  occupied entries.

## Operation
- Circular buffer with head/tail pointers of ROB_SIZE_LOG+1 bits; the extra bit is the wrap flag.
  - empty = head == tail.
  - full = index bits equal and wrap bits differ.
- Per-entry state: valid, done, pc, rd, wen, is_br, is_st, rd_data, next_pc, mem_addr, mem_data.
- Alloc accepted when alloc_valid && alloc_ready:
  - write the entry at tail with valid=1 and done=0;
  - advance tail by 1.
  - alloc_idx always shows the tail index bits.
- Writeback, when wb_valid and entry wb_idx is valid: store the payload and set done=1.
  - Writeback to an invalid entry is ignored.
  - A second writeback to the same entry overwrites the payload.
- Commit is combinational from the head and has no backpressure.
  - commit_valid = !empty && head.valid && head.done.
  - When commit_valid: clear head.valid and advance head by 1.
- Mispredict: head.is_br && wb_next_pc stored != head.pc+1, evaluated in MEMI_SIZE_LOG bits so pc+1 wraps modulo 2^MEMI_SIZE_LOG.
  - squash = commit_valid && mispredict; redirect_pc = head.next_pc.
  - On the squash edge: clear all valid bits and set tail = head+1 (the buffer becomes empty).
  - Alloc is blocked by alloc_ready=0. Any wb_valid in the squash cycle is ignored.
- A branch retires normally: commit_wen = 0, commit_st = 0 unless its alloc flags say otherwise.
- Alloc and commit in the same cycle: both take effect and count is unchanged.
  - Full blocks alloc even if a commit frees an entry in that cycle.
- Writeback and commit of the same entry in the same cycle is impossible: commit requires done already set.
- count = tail - head, in ROB_SIZE_LOG+1 bits.

## Timing
- Reset, asynchronous: head=tail=0, all valid/done=0.
  - Outputs: alloc_ready=1, alloc_idx=0, count=0.
  - All commit_* outputs, squash and redirect_pc are 0.
- Reset mid-operation discards all entries immediately; no commit or squash is emitted.
- Latency:
  - Alloc at edge N → entry valid after N.
  - Writeback at edge M → commit_valid visible in cycle M+1, when the entry is at head.
  - Minimum alloc-to-commit: 2 edges.
- Throughput: one alloc, one writeback and one commit per cycle.

## Test plan
- Reset, then allocate 4 entries with wen=1 and rd=0..3:
  - alloc_idx 0,1,2,3; count=4; alloc_ready=0 after the 4th.
  - A 5th alloc_valid is not accepted.
- Writebacks out of order (idx 2, 0, 3, 1) with data 0x22, 0x00, 0x33, 0x11:
  - commits occur in order 0,1,2,3 with rd_data 0x00, 0x11, 0x22, 0x33;
  - entry 0 commits the cycle after its writeback; 1..3 commit back-to-back after idx 1 is written.
- Full buffer, head done, alloc_valid held:
  - the commit cycle does not accept the alloc;
  - the next cycle accepts it, with alloc_idx = old head index and wrap bit toggled.
- Branch at pc=5 written back with next_pc=9, followed by 2 younger valid entries:
  - at retirement squash=1, redirect_pc=9;
  - next cycle count=0; younger entries never commit.
- Branch at pc=5 with next_pc=6 → commits with squash=0; the next entry commits normally.
- Store at idx 1 written back with mem_addr=3, mem_data=0x7 → at retirement commit_st=1, commit_mem_addr=3, commit_mem_data=0x7, commit_wen=0.
